spi_slave: RTL and testbench



---
 rtl/spi_pkg.sv | 21 ++
 rtl/spi_sync_edge.sv | 31 +++
 rtl/spi_slave.sv | 140 ++++++++++++++
 tb/tb_spi_slave.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI constants and mode decoding for master and slave
package spi_pkg;

    localparam int BITS_PER_BYTE = 8;
    localparam int CNT_W = $clog2(BITS_PER_BYTE);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BITS_PER_BYTE - 1);

    typedef enum logic {
        ST_IDLE,
        ST_ACTIVE
    } spi_state_t;

    function automatic logic mode_cpol(input int mode);
        return (mode == 2) || (mode == 3);
    endfunction

    function automatic logic mode_cpha(input int mode);
        return (mode == 1) || (mode == 3);
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - 3-flop synchronizer with rise/fall pulses taken from s2 vs s3
module spi_sync_edge #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic s1, s2, s3;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            s1 <= RESET_VAL;
            s2 <= RESET_VAL;
            s3 <= RESET_VAL;
        end else begin
            s1 <= async_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign level = s2;
    assign rise  = s2 & ~s3;
    assign fall  = ~s2 & s3;

endmodule

// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - oversampling SPI slave, all four modes, one-entry TX holding register
module spi_slave
    import spi_pkg::*;
#(
    parameter int         SPI_MODE     = 0,
    parameter logic [7:0] TX_IDLE_BYTE = 8'hFF
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    output logic       o_RX_DV,
    output logic [7:0] o_RX_Byte,
    input  logic       i_TX_DV,
    input  logic [7:0] i_TX_Byte,
    output logic       o_TX_Ready,
    input  logic       i_SPI_Clk,
    input  logic       i_SPI_MOSI,
    input  logic       i_SPI_CS_n,
    output logic       o_SPI_MISO,
    output logic       o_SPI_MISO_En
);

    localparam logic CPOL = mode_cpol(SPI_MODE);
    localparam logic CPHA = mode_cpha(SPI_MODE);

    logic sck_level_unused, sck_rise, sck_fall;
    logic mosi_s2, mosi_rise_unused, mosi_fall_unused;
    logic cs_n_s2, cs_rise, cs_fall;

    spi_sync_edge #(.RESET_VAL(CPOL)) u_sync_sck (
        .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .async_in(i_SPI_Clk),
        .level(sck_level_unused), .rise(sck_rise), .fall(sck_fall)
    );

    spi_sync_edge #(.RESET_VAL(1'b0)) u_sync_mosi (
        .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .async_in(i_SPI_MOSI),
        .level(mosi_s2), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    spi_sync_edge #(.RESET_VAL(1'b1)) u_sync_cs (
        .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .async_in(i_SPI_CS_n),
        .level(cs_n_s2), .rise(cs_rise), .fall(cs_fall)
    );

    spi_state_t state, state_next;
    logic start, stop;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) state <= ST_IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        start      = 1'b0;
        stop       = 1'b0;
        case (state)
            ST_IDLE:   if (cs_fall) begin state_next = ST_ACTIVE; start = 1'b1; end
            ST_ACTIVE: if (cs_rise) begin state_next = ST_IDLE;   stop  = 1'b1; end
            default:   state_next = ST_IDLE;
        endcase
    end

    // SCK edges count only inside an established select window
    logic qual, lead_edge, trail_edge, sample_edge, shift_edge;
    assign qual        = (state == ST_ACTIVE) & ~cs_n_s2;
    assign lead_edge   = qual & (CPOL ? sck_fall : sck_rise);
    assign trail_edge  = qual & (CPOL ? sck_rise : sck_fall);
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge  : trail_edge;

    logic [CNT_W-1:0]         rx_cnt, tx_cnt, tx_cnt_dec;
    logic [BITS_PER_BYTE-2:0] rx_shift;
    logic [7:0]               tx_shift, tx_hold, tx_next_byte;
    logic                     boundary, reload;

    assign tx_cnt_dec   = tx_cnt - 1'b1;
    assign boundary     = shift_edge & (tx_cnt == '0);
    assign reload       = start | boundary;
    assign tx_next_byte = o_TX_Ready ? TX_IDLE_BYTE : tx_hold;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            rx_cnt    <= CNT_MAX;
            rx_shift  <= '0;
            o_RX_Byte <= 8'h00;
            o_RX_DV   <= 1'b0;
        end else begin
            o_RX_DV <= 1'b0;
            if (start || stop) begin
                rx_cnt <= CNT_MAX;
            end else if (sample_edge) begin
                rx_shift <= {rx_shift[BITS_PER_BYTE-3:0], mosi_s2};
                rx_cnt   <= rx_cnt - 1'b1;
                if (rx_cnt == '0) begin
                    o_RX_Byte <= {rx_shift, mosi_s2};
                    o_RX_DV   <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            tx_cnt        <= CNT_MAX;
            tx_shift      <= 8'h00;
            o_SPI_MISO    <= 1'b0;
            o_SPI_MISO_En <= 1'b0;
        end else if (start) begin
            tx_cnt        <= CNT_MAX;
            tx_shift      <= tx_next_byte;
            o_SPI_MISO_En <= 1'b1;
            if (!CPHA) o_SPI_MISO <= tx_next_byte[7];
        end else if (stop) begin
            tx_cnt        <= CNT_MAX;
            o_SPI_MISO    <= 1'b0;
            o_SPI_MISO_En <= 1'b0;
        end else if (shift_edge) begin
            tx_cnt <= tx_cnt_dec;
            if (boundary) tx_shift <= tx_next_byte;
            // CPHA=1 drives the current bit; CPHA=0 already showed it and moves on
            if (CPHA)          o_SPI_MISO <= tx_shift[tx_cnt];
            else if (boundary) o_SPI_MISO <= tx_next_byte[7];
            else               o_SPI_MISO <= tx_shift[tx_cnt_dec];
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            tx_hold    <= 8'h00;
            o_TX_Ready <= 1'b1;
        end else if (reload && !o_TX_Ready) begin
            if (i_TX_DV) tx_hold    <= i_TX_Byte;
            else         o_TX_Ready <= 1'b1;
        end else if (i_TX_DV && o_TX_Ready) begin
            tx_hold    <= i_TX_Byte;
            o_TX_Ready <= 1'b0;
        end
    end

endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - directed and randomized bench driving one slave per SPI mode
module tb_spi_slave;

    logic       clk = 1'b0;
    logic       rst_l;
    logic       mosi;
    logic [7:0] tx_byte;
    logic [3:0] sck, cs_n, tx_dv, rx_dv, tx_ready, miso, miso_en;
    logic [7:0] rx_byte [4];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_slave #(.SPI_MODE(g), .TX_IDLE_BYTE(8'hFF)) u_dut (
            .i_Clk(clk), .i_Rst_L(rst_l),
            .o_RX_DV(rx_dv[g]), .o_RX_Byte(rx_byte[g]),
            .i_TX_DV(tx_dv[g]), .i_TX_Byte(tx_byte), .o_TX_Ready(tx_ready[g]),
            .i_SPI_Clk(sck[g]), .i_SPI_MOSI(mosi), .i_SPI_CS_n(cs_n[g]),
            .o_SPI_MISO(miso[g]), .o_SPI_MISO_En(miso_en[g])
        );
    end

    int checks = 0;
    int errors = 0;
    int cur = 0;
    bit         slot_v [4];
    logic [7:0] slot_d [4];
    logic [7:0] rxq [$];
    logic [7:0] mo_b [4];
    logic [7:0] ml_b [4];
    bit         ml_en [4];
    logic [7:0] got_b [4];
    logic [7:0] exp_b [5];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (rx_dv[cur] === 1'b1) rxq.push_back(rx_byte[cur]);
    endtask

    task automatic stepn(input int n);
        repeat (n) step();
    endtask

    // Reference model of the one-entry holding buffer: a byte slot emptied by each byte start
    function automatic logic [7:0] consume(input int m);
        logic [7:0] b;
        b = slot_v[m] ? slot_d[m] : 8'hFF;
        slot_v[m] = 1'b0;
        return b;
    endfunction

    task automatic load_tx(input int m, input logic [7:0] b);
        int n = 0;
        while (tx_ready[m] !== 1'b1 && n < 200) begin step(); n++; end
        chk("tx_ready_before_load", tx_ready[m], 1);
        tx_byte = b;
        tx_dv[m] = 1'b1;
        if (!slot_v[m]) begin slot_v[m] = 1'b1; slot_d[m] = b; end
        step();
        tx_dv[m] = 1'b0;
        chk("tx_ready_after_load", tx_ready[m], slot_v[m] ? 0 : 1);
    endtask

    task automatic clear_ml();
        for (int i = 0; i < 4; i++) ml_en[i] = 1'b0;
    endtask

    task automatic xfer(input int m, input int nbytes, input int cut_bits, input bit do_reset);
        logic cpol, cpha, pre;
        int   bits;
        bit   done;
        cpol = (m >= 2);
        cpha = (m % 2 == 1);
        cur = m;
        rxq.delete();
        bits = 0;
        done = 1'b0;
        for (int i = 0; i < 4; i++) got_b[i] = 8'h00;
        exp_b[0] = consume(m);
        cs_n[m] = 1'b0;
        stepn(8);
        chk("tx_ready_after_cs", tx_ready[m], slot_v[m] ? 0 : 1);
        chk("miso_en_active", miso_en[m], 1);
        for (int k = 0; k < nbytes && !done; k++) begin
            for (int b = 7; b >= 0 && !done; b--) begin
                if (!cpha) mosi = mo_b[k][b];
                stepn(4);
                pre = miso[m];
                stepn(4);
                if (!cpha) begin
                    got_b[k][b] = miso[m];
                    chk("miso_stable", miso[m], pre);
                end
                sck[m] = ~cpol;
                stepn(4);
                if (cpha) mosi = mo_b[k][b];
                pre = miso[m];
                stepn(4);
                if (cpha) begin
                    got_b[k][b] = miso[m];
                    chk("miso_stable", miso[m], pre);
                end
                sck[m] = cpol;
                bits++;
                if (b == 4 && ml_en[k]) load_tx(m, ml_b[k]);
                if (b == 0) exp_b[k+1] = consume(m);
                if (bits == cut_bits) done = 1'b1;
            end
        end
        if (do_reset) begin
            rst_l = 1'b0;
            #1;
            chk("rst_rx_dv", rx_dv[m], 0);
            chk("rst_rx_byte", rx_byte[m], 0);
            chk("rst_tx_ready", tx_ready[m], 1);
            chk("rst_miso", miso[m], 0);
            chk("rst_miso_en", miso_en[m], 0);
            for (int i = 0; i < 4; i++) slot_v[i] = 1'b0;
            sck = 4'b1100;
            cs_n = 4'hF;
            mosi = 1'b0;
            stepn(3);
            rst_l = 1'b1;
            stepn(2);
        end else begin
            stepn(8);
            cs_n[m] = 1'b1;
            stepn(8);
            chk("miso_en_idle", miso_en[m], 0);
            chk("miso_idle", miso[m], 0);
        end
    endtask

    task automatic check_full(input int nbytes);
        chk("rx_pulse_count", rxq.size(), nbytes);
        for (int i = 0; i < nbytes; i++) begin
            chk("rx_byte", (i < rxq.size()) ? rxq[i] : 8'hxx, mo_b[i]);
            chk("miso_byte", got_b[i], exp_b[i]);
        end
    endtask

    initial begin
        int m, n;
        rst_l = 1'b0;
        mosi = 1'b0;
        tx_byte = 8'h00;
        tx_dv = 4'h0;
        sck = 4'b1100;
        cs_n = 4'hF;
        clear_ml();
        for (int i = 0; i < 4; i++) slot_v[i] = 1'b0;
        stepn(3);
        for (int i = 0; i < 4; i++) begin
            chk("reset_rx_dv", rx_dv[i], 0);
            chk("reset_rx_byte", rx_byte[i], 0);
            chk("reset_tx_ready", tx_ready[i], 1);
            chk("reset_miso", miso[i], 0);
            chk("reset_miso_en", miso_en[i], 0);
        end
        rst_l = 1'b1;
        stepn(3);

        load_tx(0, 8'h3C);
        mo_b[0] = 8'hA5;
        xfer(0, 1, -1, 1'b0);
        check_full(1);
        chk("mode0_miso_3c", got_b[0], 8'h3C);

        for (int md = 1; md < 4; md++) begin
            load_tx(md, 8'h7E);
            mo_b[0] = 8'h81;
            xfer(md, 1, -1, 1'b0);
            check_full(1);
        end

        for (int md = 0; md < 4; md++) begin
            load_tx(md, 8'h11);
            ml_en[0] = 1'b1; ml_b[0] = 8'h22;
            ml_en[1] = 1'b1; ml_b[1] = 8'h33;
            mo_b[0] = 8'hDE; mo_b[1] = 8'hAD; mo_b[2] = 8'hBE;
            xfer(md, 3, -1, 1'b0);
            check_full(3);
            clear_ml();
        end

        ml_en[0] = 1'b1; ml_b[0] = 8'h42;
        mo_b[0] = 8'h96; mo_b[1] = 8'h0F;
        xfer(1, 2, -1, 1'b0);
        check_full(2);
        clear_ml();

        for (int md = 0; md < 2; md++) begin
            mo_b[0] = 8'hC3;
            xfer(md, 1, 5, 1'b0);
            chk("abort_no_rx", rxq.size(), 0);
            mo_b[0] = 8'h5A;
            load_tx(md, 8'h6B);
            xfer(md, 1, -1, 1'b0);
            check_full(1);
        end

        load_tx(0, 8'h99);
        mo_b[0] = 8'hE7;
        xfer(0, 1, 3, 1'b1);
        chk("post_reset_ready", tx_ready[0], 1);
        load_tx(0, 8'h24);
        mo_b[0] = 8'h5A;
        xfer(0, 1, -1, 1'b0);
        check_full(1);

        for (int t = 0; t < 8; t++) begin
            m = $urandom_range(0, 3);
            n = $urandom_range(1, 3);
            for (int i = 0; i < 4; i++) begin
                mo_b[i] = 8'($urandom);
                ml_b[i] = 8'($urandom);
                ml_en[i] = (i < n - 1) && ($urandom_range(0, 1) == 1);
            end
            if ($urandom_range(0, 1) == 1) load_tx(m, 8'($urandom));
            xfer(m, n, -1, 1'b0);
            check_full(n);
            clear_ml();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
